store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of 2, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, address and data width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port flush_i, input, 1 bit: discard all unissued entries.
REQ-006 SHALL have port push_i, input, 1 bit: store request from the store unit.
REQ-007 SHALL have ports push_address_i, input, XLEN bits, and push_data_i, input, XLEN bits: store address and data.
REQ-008 SHALL have port push_width_i, input, 2 bits: store width (0 byte, 1 half, 2 word; 3 reserved).
REQ-009 SHALL have port push_done_o, output, 1 bit: push accepted pulse.
REQ-010 SHALL have port misaligned_o, output, 1 bit: push rejected pulse (misaligned or reserved width).
REQ-011 SHALL have ports full_o, output, 1 bit, and empty_o, output, 1 bit: occupancy flags.
REQ-012 SHALL have port store_request_o, output, 1 bit: memory store request.
REQ-013 SHALL have ports store_address_o, output, XLEN bits, store_data_o, output, XLEN bits, and store_width_o, output, 2 bits: head entry fields.
REQ-014 SHALL have port store_done_i, input, 1 bit: memory completed the current store.
REQ-015 SHALL have ports load_address_i, input, XLEN bits, load_match_o, output, 1 bit, and load_data_o, output, XLEN bits: forwarding lookup.

Function
REQ-016 SHALL be a circular FIFO of DEPTH entries {address, data, width} with read/write pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-017 SHALL accept a push when push_i=1, full_o=0, flush_i=0 and the push is aligned, writing at the tail and pulsing push_done_o=1 in the same cycle.
REQ-018 SHALL reject a push when full_o=1, even if a pop occurs in the same cycle; push_done_o=0 and the entry is not written.
REQ-019 SHALL treat half with address[0]=1, word with address[1:0]!=0, or width 3 as misaligned: no write, misaligned_o=1 for that cycle.
REQ-020 SHALL implement FSM IDLE/WAIT: IDLE->WAIT when count>0; WAIT->IDLE on store_done_i=1 with count after pop =0; otherwise stay in WAIT.
REQ-021 SHALL drive store_request_o=1 exactly in WAIT, with store_* outputs equal to the head entry and held stable until store_done_i.
REQ-022 SHALL pop the head on store_done_i=1 in WAIT; a next entry appears on store_* the following cycle (one store per done, no bubble); store_done_i in IDLE is ignored.
REQ-023 SHALL give a push-to-request latency of one cycle when empty (push at cycle N, store_request_o=1 at N+1).
REQ-024 SHALL update count correctly for a simultaneous accepted push and pop (count unchanged).
REQ-025 SHALL, on flush_i in WAIT, retain only the in-flight head entry (count=1); in IDLE, empty the buffer (count=0); a push in the flush cycle is ignored.
REQ-026 SHALL, if store_done_i and flush_i coincide in WAIT, pop the head and leave the buffer empty, state IDLE.
REQ-027 SHALL assert full_o when count=DEPTH and empty_o when count=0.

Reset
REQ-028 SHALL, with rst_n_i=0 at a clock edge, set pointers and count to 0, state to IDLE, and all outputs to 0 except empty_o=1; an in-flight request is abandoned.

Configuration
REQ-029 SHALL use macro STORE_BUFFER_FORWARD_EN; when defined, load_match_o=1 combinationally if any valid word-width entry has address[XLEN-1:2] equal to load_address_i[XLEN-1:2], with load_data_o from the youngest match.
REQ-030 SHALL, without STORE_BUFFER_FORWARD_EN, keep the ports and tie load_match_o and load_data_o to 0.

Verification
REQ-031 SHALL test: reset, then push word 0x100/0xDEADBEEF -> push_done_o=1; next cycle store_request_o=1, address 0x100; done_i -> empty_o=1.
REQ-032 SHALL test: DEPTH=4, push 5 words with done_i=0 -> 4 accepted, full_o=1, 5th push_done_o=0; single done -> next head on store_* at the following cycle.
REQ-033 SHALL test: push half at 0x101 and word at 0x102 -> misaligned_o=1 each time, count stays 0.
REQ-034 SHALL test: 3 entries, WAIT, flush_i=1 -> count=1, request held; done_i -> IDLE, empty_o=1.
REQ-035 SHALL test (FORWARD_EN): push 0x200/0x11 then 0x200/0x22, load_address_i=0x200 -> load_match_o=1, load_data_o=0x22; without macro -> 0.
REQ-036 SHALL test: assert rst_n_i=0 mid-WAIT with 2 entries -> next cycle store_request_o=0, empty_o=1.

Source files
------------

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Purpose
//   Circular FIFO of DEPTH pending stores {address, data, width} between the
//   store unit and memory. The head entry is presented to memory while the
//   control FSM is in WAIT. Each store_done_i retires exactly one entry. An
//   optional lookup lets a load read data from a buffered word store.
//
// Configuration
//   STORE_BUFFER_FORWARD_EN : when defined, load_match_o/load_data_o perform a
//                             combinational word-granular lookup over valid
//                             word-width entries. The youngest match wins.
//                             When undefined, both outputs are tied to 0.
//
// Ports
//   clk_i            in   1     clock; all state updates on the rising edge
//   rst_n_i          in   1     synchronous active-low reset
//   flush_i          in   1     discard unissued entries (in-flight head kept)
//   push_i           in   1     store request from the store unit
//   push_address_i   in   XLEN  store address
//   push_data_i      in   XLEN  store data
//   push_width_i     in   2     0 byte, 1 half, 2 word, 3 reserved
//   push_done_o      out  1     push accepted this cycle
//   misaligned_o     out  1     push rejected as misaligned/reserved width
//   full_o           out  1     count == DEPTH
//   empty_o          out  1     count == 0
//   store_request_o  out  1     memory store request (high exactly in WAIT)
//   store_address_o  out  XLEN  head entry address (0 when idle)
//   store_data_o     out  XLEN  head entry data (0 when idle)
//   store_width_o    out  2     head entry width (0 when idle)
//   store_done_i     in   1     memory completed the current store
//   load_address_i   in   XLEN  forwarding lookup address
//   load_match_o     out  1     a buffered word store covers load_address_i
//   load_data_o      out  XLEN  data of the youngest matching entry
//
// Handshake semantics
//   Push side: push_i is a one-cycle offer. It is accepted in the same cycle
//   (push_done_o=1) when the buffer is not full, no flush is in progress and
//   the access is aligned. A rejected push is dropped, not held. The producer
//   must re-offer it.
//   Memory side: store_request_o is the valid and store_done_i is the ready.
//   A transfer (pop) happens in a cycle where both are high. store_* stay
//   stable while store_request_o is high and store_done_i is low.
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [XLEN-1:0] push_address_i,
  input  logic [XLEN-1:0] push_data_i,
  input  logic [1:0]      push_width_i,
  output logic            push_done_o,
  output logic            misaligned_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            store_request_o,
  output logic [XLEN-1:0] store_address_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [1:0]      store_width_o,
  input  logic            store_done_i,
  input  logic [XLEN-1:0] load_address_i,
  output logic            load_match_o,
  output logic [XLEN-1:0] load_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  // Control FSM state. Probe this signal hierarchically to observe the FSM.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Entry storage
  logic [XLEN-1:0] addr_mem  [DEPTH];
  logic [XLEN-1:0] data_mem  [DEPTH];
  logic [1:0]      width_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] wr_ptr_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic aligned;
  logic full;
  logic push_acc;
  logic pop;

  // -------------------------------------------------------------------------
  // Push qualification
  // -------------------------------------------------------------------------
  always_comb begin
    aligned = 1'b0;
    case (push_width_i)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~push_address_i[0];
      2'd2:    aligned = (push_address_i[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign full = (count == FULL_COUNT);

  // Fullness is judged on the registered count, so a pop in the same cycle
  // does not free a slot for a push.
  assign push_acc = rst_n_i & push_i & ~full & ~flush_i & aligned;
  assign pop      = rst_n_i & (state == WAIT) & store_done_i;

  // -------------------------------------------------------------------------
  // Pointer / count next values
  // -------------------------------------------------------------------------
  always_comb begin
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    count_next  = count;

    if (pop) begin
      rd_ptr_next = rd_ptr + PTR_ONE;
    end
    if (push_acc) begin
      wr_ptr_next = wr_ptr + PTR_ONE;
    end
    if (push_acc && !pop) begin
      count_next = count + CNT_ONE;
    end else if (!push_acc && pop) begin
      count_next = count - CNT_ONE;
    end

    // Flush keeps only the in-flight head, which memory may already be
    // writing. If that head retires in the same cycle, nothing is left.
    // push_acc is already 0 during a flush.
    if (flush_i) begin
      if (state == WAIT && !pop) begin
        count_next  = CNT_ONE;
        wr_ptr_next = rd_ptr + PTR_ONE;
      end else begin
        count_next  = '0;
        wr_ptr_next = rd_ptr_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // The FSM looks at the next count, so a push into an empty buffer raises
  // the request on the very next cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (count_next != '0) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (pop && count_next == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    store_request_o = 1'b0;
    store_address_o = '0;
    store_data_o    = '0;
    store_width_o   = 2'd0;
    if (state == WAIT) begin
      store_request_o = 1'b1;
      store_address_o = addr_mem[rd_ptr];
      store_data_o    = data_mem[rd_ptr];
      store_width_o   = width_mem[rd_ptr];
    end
  end

  // -------------------------------------------------------------------------
  // Pointers, count and storage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
    end
  end

  // Entry storage needs no reset. Entries are only observed while they are
  // valid, and store_* are forced to 0 outside WAIT.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      addr_mem[wr_ptr]  <= push_address_i;
      data_mem[wr_ptr]  <= push_data_i;
      width_mem[wr_ptr] <= push_width_i;
    end
  end

  // -------------------------------------------------------------------------
  // Status flags
  // -------------------------------------------------------------------------
  assign push_done_o  = push_acc;
  assign misaligned_o = rst_n_i & push_i & ~aligned;
  assign full_o       = full;
  assign empty_o      = (count == '0);

  // -------------------------------------------------------------------------
  // Store-to-load forwarding
  // -------------------------------------------------------------------------
`ifdef STORE_BUFFER_FORWARD_EN
  logic [PW-1:0] fwd_idx;

  // Walk from oldest to youngest so the last hit is the youngest store.
  always_comb begin
    load_match_o = 1'b0;
    load_data_o  = '0;
    fwd_idx      = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) &&
          (width_mem[fwd_idx] == 2'd2) &&
          (addr_mem[fwd_idx][XLEN-1:2] == load_address_i[XLEN-1:2])) begin
        load_match_o = 1'b1;
        load_data_o  = data_mem[fwd_idx];
      end
    end
  end
`else
  logic unused_load_address;
  assign unused_load_address = ^load_address_i;
  assign load_match_o        = 1'b0;
  assign load_data_o         = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//   Directed bench for store_buffer (DEPTH=4, XLEN=32). Every accepted push
//   queues the store expected on the memory side. The monitor pops and
//   compares the queue whenever a store retires (store_request_o and
//   store_done_i both high). Flags and combinational outputs are checked
//   directly against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_store_buffer;
  localparam int XLEN = 32;
  localparam int W    = 2 * XLEN + 2;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            flush_i;
  logic            push_i;
  logic [XLEN-1:0] push_address_i;
  logic [XLEN-1:0] push_data_i;
  logic [1:0]      push_width_i;
  logic            push_done_o;
  logic            misaligned_o;
  logic            full_o;
  logic            empty_o;
  logic            store_request_o;
  logic [XLEN-1:0] store_address_o;
  logic [XLEN-1:0] store_data_o;
  logic [1:0]      store_width_o;
  logic            store_done_i;
  logic [XLEN-1:0] load_address_i;
  logic            load_match_o;
  logic [XLEN-1:0] load_data_o;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  store_buffer #(.DEPTH(4), .XLEN(XLEN)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .flush_i        (flush_i),
    .push_i         (push_i),
    .push_address_i (push_address_i),
    .push_data_i    (push_data_i),
    .push_width_i   (push_width_i),
    .push_done_o    (push_done_o),
    .misaligned_o   (misaligned_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .store_request_o(store_request_o),
    .store_address_o(store_address_o),
    .store_data_o   (store_data_o),
    .store_width_o  (store_width_o),
    .store_done_i   (store_done_i),
    .load_address_i (load_address_i),
    .load_match_o   (load_match_o),
    .load_data_o    (load_data_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- checkers ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [XLEN-1:0] act,
                            input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] mon_exp;
  always @(negedge clk_i) begin
    if (rst_n_i && store_request_o && store_done_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL store_beat: got addr 0x%0h with nothing expected", store_address_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({store_address_o, store_data_o, store_width_o} !== mon_exp) begin
          bad++;
          $display("FAIL store_beat: got 0x%0h/0x%0h/%0d expected 0x%0h/0x%0h/%0d",
                   store_address_o, store_data_o, store_width_o,
                   mon_exp[W-1:XLEN+2], mon_exp[XLEN+1:2], mon_exp[1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d,
                      input logic [1:0] w, input logic exp_done,
                      input logic exp_mis, input string tag);
    push_i         = 1'b1;
    push_address_i = a;
    push_data_i    = d;
    push_width_i   = w;
    #1;
    check_bit({tag, "_done"}, push_done_o, exp_done);
    check_bit({tag, "_mis"}, misaligned_o, exp_mis);
    if (exp_done) exp_q.push_back({a, d, w});
    tick();
    push_i = 1'b0;
  endtask

  task automatic done_cycles(input int n);
    store_done_i = 1'b1;
    repeat (n) tick();
    store_done_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n_i        = 1'b0;
    flush_i        = 1'b0;
    push_i         = 1'b1;      // offered during reset, must be ignored
    push_address_i = 32'h100;
    push_data_i    = 32'h1;
    push_width_i   = 2'd2;
    store_done_i   = 1'b0;
    load_address_i = 32'h0;
    repeat (2) tick();

    // Reset state
    check_bit("rst_request", store_request_o, 1'b0);
    check_bit("rst_empty", empty_o, 1'b1);
    check_bit("rst_full", full_o, 1'b0);
    check_bit("rst_push_done", push_done_o, 1'b0);
    check_bit("rst_misaligned", misaligned_o, 1'b0);
    check_word("rst_store_addr", store_address_o, 32'h0);
    check_bit("rst_load_match", load_match_o, 1'b0);
    push_i  = 1'b0;
    rst_n_i = 1'b1;
    tick();
    check_bit("post_rst_empty", empty_o, 1'b1);

    // Single store: one-cycle push-to-request latency
    push(32'h100, 32'hDEADBEEF, 2'd2, 1'b1, 1'b0, "t1_push");
    check_bit("t1_request", store_request_o, 1'b1);
    check_word("t1_addr", store_address_o, 32'h100);
    check_word("t1_data", store_data_o, 32'hDEADBEEF);
    check_bit("t1_not_empty", empty_o, 1'b0);
    done_cycles(1);
    check_bit("t1_empty", empty_o, 1'b1);
    check_bit("t1_idle", store_request_o, 1'b0);

    // Fill to DEPTH, fifth push rejected, then pop one at a time
    push(32'h10, 32'hA0, 2'd2, 1'b1, 1'b0, "t2_p0");
    push(32'h14, 32'hA1, 2'd2, 1'b1, 1'b0, "t2_p1");
    push(32'h18, 32'hA2, 2'd2, 1'b1, 1'b0, "t2_p2");
    push(32'h1c, 32'hA3, 2'd2, 1'b1, 1'b0, "t2_p3");
    check_bit("t2_full", full_o, 1'b1);
    push(32'h20, 32'hA4, 2'd2, 1'b0, 1'b0, "t2_p4_rej");
    check_word("t2_head_held", store_address_o, 32'h10);
    done_cycles(1);
    check_bit("t2_request", store_request_o, 1'b1);
    check_word("t2_next_head", store_address_o, 32'h14);
    check_bit("t2_not_full", full_o, 1'b0);
    done_cycles(3);
    check_bit("t2_empty", empty_o, 1'b1);
    check_bit("t2_idle", store_request_o, 1'b0);

    // Alignment rules
    push(32'h101, 32'h5, 2'd1, 1'b0, 1'b1, "t3_half_odd");
    push(32'h102, 32'h6, 2'd2, 1'b0, 1'b1, "t3_word_mis");
    push(32'h100, 32'h7, 2'd3, 1'b0, 1'b1, "t3_reserved");
    check_bit("t3_empty", empty_o, 1'b1);
    check_bit("t3_idle", store_request_o, 1'b0);
    push(32'h103, 32'h8, 2'd0, 1'b1, 1'b0, "t3_byte");
    check_word("t3_byte_width", {30'b0, store_width_o}, 32'h0);
    check_word("t3_byte_addr", store_address_o, 32'h103);
    done_cycles(1);

    // Flush in WAIT keeps the in-flight head; push in flush cycle is ignored
    push(32'h300, 32'hB0, 2'd2, 1'b1, 1'b0, "t4_p0");
    push(32'h304, 32'hB1, 2'd2, 1'b1, 1'b0, "t4_p1");
    push(32'h308, 32'hB2, 2'd2, 1'b1, 1'b0, "t4_p2");
    flush_i        = 1'b1;
    push_i         = 1'b1;
    push_address_i = 32'h400;
    push_data_i    = 32'hB3;
    push_width_i   = 2'd2;
    #1;
    check_bit("t4_flush_push", push_done_o, 1'b0);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    tick();
    flush_i = 1'b0;
    push_i  = 1'b0;
    check_bit("t4_request_held", store_request_o, 1'b1);
    check_word("t4_head", store_address_o, 32'h300);
    check_bit("t4_not_empty", empty_o, 1'b0);
    done_cycles(1);
    check_bit("t4_empty", empty_o, 1'b1);
    check_bit("t4_idle", store_request_o, 1'b0);

    // Flush together with done empties the buffer; pointers stay usable
    push(32'h500, 32'hC0, 2'd2, 1'b1, 1'b0, "t5_p0");
    push(32'h504, 32'hC1, 2'd2, 1'b1, 1'b0, "t5_p1");
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    flush_i      = 1'b1;
    store_done_i = 1'b1;
    tick();
    flush_i      = 1'b0;
    store_done_i = 1'b0;
    check_bit("t5_empty", empty_o, 1'b1);
    check_bit("t5_idle", store_request_o, 1'b0);
    push(32'h600, 32'hC2, 2'd2, 1'b1, 1'b0, "t5_after");
    check_word("t5_after_addr", store_address_o, 32'h600);
    done_cycles(1);

    // Forwarding lookup
    load_address_i = 32'h200;
    push(32'h200, 32'h11, 2'd2, 1'b1, 1'b0, "t6_p0");
    push(32'h200, 32'h22, 2'd2, 1'b1, 1'b0, "t6_p1");
    push(32'h208, 32'h33, 2'd1, 1'b1, 1'b0, "t6_half");
    #1;
`ifdef STORE_BUFFER_FORWARD_EN
    check_bit("t6_match", load_match_o, 1'b1);
    check_word("t6_youngest", load_data_o, 32'h22);
    load_address_i = 32'h203;
    #1;
    check_bit("t6_match_byte", load_match_o, 1'b1);
    check_word("t6_data_byte", load_data_o, 32'h22);
`else
    check_bit("t6_match_off", load_match_o, 1'b0);
    check_word("t6_data_off", load_data_o, 32'h0);
`endif
    load_address_i = 32'h204;
    #1;
    check_bit("t6_miss", load_match_o, 1'b0);
    check_word("t6_miss_data", load_data_o, 32'h0);
    load_address_i = 32'h208;
    #1;
    check_bit("t6_half_ignored", load_match_o, 1'b0);
    tick();
    done_cycles(3);
    check_bit("t6_empty", empty_o, 1'b1);

    // Reset in the middle of WAIT abandons the request
    push(32'h700, 32'hD0, 2'd2, 1'b1, 1'b0, "t7_p0");
    push(32'h704, 32'hD1, 2'd2, 1'b1, 1'b0, "t7_p1");
    check_bit("t7_request", store_request_o, 1'b1);
    rst_n_i = 1'b0;
    exp_q.delete();
    tick();
    check_bit("t7_request_dropped", store_request_o, 1'b0);
    check_bit("t7_empty", empty_o, 1'b1);
    rst_n_i = 1'b1;
    tick();
    check_bit("t7_stays_idle", store_request_o, 1'b0);

    check_word("queue_drained", XLEN'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
